// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes used by decode
// and the sequencer state type.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle on magnitudes, sign fix-up
// in a single cycle, then a one-cycle HI/LO write strobe toward the register file.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_data,
  output logic [WIDTH-1:0] lo_data
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, neg_res, neg_rem, div_zero;

  logic               launch, last_iter;
  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] acc_nxt, prod;
  logic [WIDTH-1:0]   quo, rem, hi_fix, lo_fix;

  always_comb begin
    launch    = ((state == ST_IDLE) || (state == ST_DONE)) && start && !cancel;
    last_iter = (cnt == CW'(WIDTH - 1));
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (launch) state_nxt = ST_CALC;
      ST_CALC: begin
        if (cancel)         state_nxt = ST_IDLE;
        else if (last_iter) state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = cancel ? ST_IDLE : ST_DONE;
      ST_DONE: state_nxt = launch ? ST_CALC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy  = (state == ST_CALC) || (state == ST_FIX);
  assign done  = (state == ST_DONE);
  assign hi_we = done;
  assign lo_we = done;

  // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = rem_sh - {1'b0, opnd};
    if (is_div) begin
      if (diff[WIDTH]) acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // With a zero divisor every trial subtract succeeds, so the remainder is the dividend
  // magnitude and restoring its sign reproduces the raw dividend for HI.
  always_comb begin
    prod = neg_res ? -acc : acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      hi_fix = neg_rem ? -rem : rem;
      if (div_zero)     lo_fix = '1;
      else if (neg_res) lo_fix = -quo;
      else              lo_fix = quo;
    end else begin
      hi_fix = prod[2*WIDTH-1:WIDTH];
      lo_fix = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_data  <= '0;
      lo_data  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (launch) begin
            cnt      <= '0;
            is_div   <= op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= op[1] && (b == '0);
            if (op[1]) begin
              opnd <= b_mag;
              acc  <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              opnd <= a_mag;
              acc  <= {{WIDTH{1'b0}}, b_mag};
            end
          end
        end
        ST_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
        end
        ST_FIX: begin
          if (!cancel) begin
            hi_data <= hi_fix;
            lo_data <= lo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO pushed at issue, popped on done.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst, start, cancel;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, hi_we, lo_we;
  logic [WIDTH-1:0] hi_data, lo_data;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } result_t;

  result_t     exp_q[$];
  int          vectors    = 0;
  int          miscompares = 0;
  int          done_seen  = 0;
  logic [31:0] last_hi    = '0;
  logic [31:0] last_lo    = '0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .done(done), .hi_we(hi_we), .lo_we(lo_we),
    .hi_data(hi_data), .lo_data(lo_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic result_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    result_t     r;
    logic [63:0] p;
    int          sx, sy;
    sx = x;
    sy = y;
    p  = '0;
    r  = '0;
    case (o)
      OP_MULT:  begin p = longint'(sx) * longint'(sy); r = p; end
      OP_MULTU: begin p = {32'b0, x} * {32'b0, y};     r = p; end
      default: begin
        if (y == 0) begin
          r.lo = '1;
          r.hi = x;
        end else if (o == OP_DIVU) begin
          r.lo = x / y;
          r.hi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          r.lo = 32'h8000_0000;
          r.hi = '0;
        end else begin
          r.lo = sx / sy;
          r.hi = sx % sy;
        end
      end
    endcase
    return r;
  endfunction

  // Every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      result_t e;
      done_seen++;
      checkOutput("hi_we", 64'(hi_we), 64'd1);
      checkOutput("lo_we", 64'(lo_we), 64'd1);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("hi_data", 64'(hi_data), 64'(e.hi));
        checkOutput("lo_data", 64'(lo_data), 64'(e.lo));
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input bit expect_result);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (expect_result) exp_q.push_back(model(o, x, y));
  endtask

  // Counts cycles after the issue edge until done; a stray start can be injected mid-flight.
  task automatic waitDone(input int ignore_at, output int n, output int busy_n, output bit early);
    n      = 0;
    busy_n = 0;
    early  = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
      end
      if (n == ignore_at) begin
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd99;
        b     = 32'd99;
      end
      if (n == ignore_at + 1) start = 1'b0;
      if (done) break;
      if (busy) busy_n++;
      if (hi_we || lo_we) early = 1'b1;
    end
    if (!done) checkOutput("done_timeout", 64'(n), 64'(WIDTH + 2));
    checkOutput("busy_at_done", 64'(busy), 64'd0);
  endtask

  task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int n, bn;
    bit early;
    applyStimulus(o, x, y, 1'b1);
    waitDone(0, n, bn, early);
    checkOutput("latency", 64'(n), 64'(WIDTH + 2));
    checkOutput("busy_cycles", 64'(bn), 64'(WIDTH + 1));
    checkOutput("early_strobe", 64'(early), 64'd0);
    @(negedge clk);
    checkOutput("strobe_pulse", {61'b0, done, hi_we, lo_we}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, bn, seen;
    bit early;
    logic [31:0] pre_hi, pre_lo;

    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", {60'b0, busy, done, hi_we, lo_we}, 64'd0);
    checkOutput("reset_hi", 64'(hi_data), 64'd0);
    checkOutput("reset_lo", 64'(lo_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    runOp(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002);
    runOp(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    runOp(OP_DIVU,  32'd100,       32'd7);
    runOp(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    runOp(OP_DIVU,  32'd5,         32'd0);
    runOp(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    runOp(OP_DIV,   32'hFFFF_FFF0, 32'd0);
    runOp(OP_DIV,   32'd17,        32'hFFFF_FFFB);
    for (int i = 0; i < 8; i++) begin
      runOp(2'(i % 4), $urandom, (i > 3) ? 32'($urandom_range(1, 300)) : $urandom);
    end

    // Cancel mid-CALC: nothing retires and the last result stays visible.
    pre_hi = last_hi;
    pre_lo = last_lo;
    seen   = done_seen;
    applyStimulus(OP_MULTU, 32'd3, 32'd4, 1'b0);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checkOutput("cancel_busy", 64'(busy), 64'd0);
    repeat (WIDTH + 4) @(negedge clk);
    checkOutput("cancel_no_done", 64'(done_seen - seen), 64'd0);
    checkOutput("cancel_hi_hold", 64'(hi_data), 64'(pre_hi));
    checkOutput("cancel_lo_hold", 64'(lo_data), 64'(pre_lo));

    // Asynchronous reset mid-CALC clears everything before the next edge.
    seen = done_seen;
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_ctrl", {60'b0, busy, done, hi_we, lo_we}, 64'd0);
    checkOutput("rst_mid_hi", 64'(hi_data), 64'd0);
    checkOutput("rst_mid_lo", 64'(lo_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);
    checkOutput("rst_no_done", 64'(done_seen - seen), 64'd0);

    // Back-to-back issue from DONE, with a stray start while busy that must be ignored.
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b1);
    waitDone(0, n, bn, early);
    checkOutput("b2b_first_latency", 64'(n), 64'(WIDTH + 2));
    applyStimulus(OP_MULTU, 32'd6, 32'd7, 1'b1);
    waitDone(5, n, bn, early);
    checkOutput("b2b_second_latency", 64'(n), 64'(WIDTH + 2));
    checkOutput("b2b_busy_cycles", 64'(bn), 64'(WIDTH + 1));
    @(negedge clk);
    checkOutput("b2b_idle", {61'b0, busy, done, hi_we}, 64'd0);
    repeat (WIDTH + 4) @(negedge clk);
    checkOutput("b2b_hi_final", 64'(hi_data), 64'd0);
    checkOutput("b2b_lo_final", 64'(lo_data), 64'h2A);

    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that produces the 64-bit HI/LO results consumed by the register file.
- Drives hi/lo data plus one-cycle HI/LO write strobes that connect directly to the register file's HiWrite/LoWrite and HI/LO data inputs.
- Handles MULT, MULTU, DIV and DIVU with one-bit-per-cycle shift-add multiply and restoring divide.
- Asserts busy so the core can stall MFHI/MFLO or a new mul/div while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, iteration count = WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  launch an operation; sampled only when busy=0
- op  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- cancel  in  1  synchronous abort (exception flush); no result written
- busy  out  1  operation in progress (CALC or FIX)
- done  out  1  one-cycle pulse, result valid
- hi_we  out  1  HI write strobe; equals done
- lo_we  out  1  LO write strobe; equals done
- hi_data  out  WIDTH  HI result (product upper half / remainder)
- lo_data  out  WIDTH  LO result (product lower half / quotient)

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, hi_we, lo_we = 0; hi_data, lo_data = 0; internal counter and accumulators cleared. Reset mid-operation discards the operation and produces no strobe.
- States: IDLE, CALC, FIX, DONE.
- IDLE or DONE, start=1 at edge E0: latch op, a, b; compute operand magnitudes (signed ops only) and result signs; counter=0; go to CALC. start is ignored while busy=1.
- CALC: one iteration per cycle, WIDTH cycles (counter 0..WIDTH-1), then go to FIX.
  - Multiply: 2*WIDTH accumulator; add the multiplicand when the current multiplier LSB is 1, then shift right.
  - Divide: restoring. Shift the remainder left, bring in the dividend MSB, trial-subtract the divisor, set the quotient bit if the result is non-negative.
- FIX (1 cycle), then go to DONE:
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Load hi_data and lo_data.
- DONE (1 cycle): done=hi_we=lo_we=1, then go to IDLE, unless start=1, in which case go back to CALC (back-to-back issue).
- Timing: done is high in the cycle after edge E(WIDTH+1), i.e. WIDTH+2 cycles after the start cycle. busy is high from E0+1 through the FIX cycle. busy=0 in IDLE and DONE.
- hi_data and lo_data hold their value until the next FIX; they are never altered by cancel.
- Divide by zero (b=0, DIV or DIVU): lo_data=all ones, hi_data=a (the raw dividend); sign correction is bypassed. No exception is raised.
- Signed overflow (DIV 0x8000_0000 / 0xFFFF_FFFF): lo_data=0x8000_0000, hi_data=0. This falls out of the magnitude path naturally.
- cancel=1: in CALC or FIX, go to IDLE next edge with no done/strobes. In DONE, the strobes still fire that cycle (the write already committed). cancel has priority over a same-cycle start.
- Operand changes on a or b after E0 have no effect.

Decomposition:
- Shared package muldiv_pkg: op encoding constants (OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3) and state encoding constants. The decode stage uses the same constants.
- No sub-module: a single module with a shared accumulator/counter. The sign-magnitude pre/post logic stays inline.

Test Plan:
- MULT a=0xFFFF_FFFF, b=0x0000_0002 -> after WIDTH+2 cycles done=1 with hi_data=0xFFFF_FFFF, lo_data=0xFFFF_FFFE; hi_we=lo_we=1 for exactly one cycle.
- MULTU a=0xFFFF_FFFF, b=0x0000_0002 -> hi_data=0x0000_0001, lo_data=0xFFFF_FFFE; busy high exactly WIDTH+1 cycles.
- DIVU a=100, b=7 -> lo_data=0x0000_000E, hi_data=0x0000_0002. DIV a=-7 (0xFFFF_FFF9), b=2 -> lo_data=0xFFFF_FFFD, hi_data=0xFFFF_FFFF.
- DIVU a=5, b=0 -> lo_data=0xFFFF_FFFF, hi_data=0x0000_0005. DIV a=0x8000_0000, b=0xFFFF_FFFF -> lo_data=0x8000_0000, hi_data=0.
- Start MULTU 3*4, pulse cancel at CALC cycle 10 -> no done/strobes; hi_data and lo_data keep their previous values; busy=0 the next cycle. Repeat with rst asserted mid-CALC -> all outputs 0 immediately.
- Back-to-back: start held during DONE of DIVU 100/7 with new op MULTU 6*7 -> first done yields 0xE/0x2; the second done follows WIDTH+2 cycles later with hi_data=0, lo_data=0x2A. start asserted while busy=1 is ignored.
